// File: rtl/udp_tx_app_arbiter.sv
// Two-requester UDP TX arbiter: grants one header+payload packet at a time and
// alternates fairly between requesters under contention.
package udp_tx_app_arbiter_pkg;
  localparam int unsigned IP_ADDR_W       = 32;
  localparam int unsigned MAC_INTERFACE_W = 64;
  localparam int unsigned MAC_PADBYTES_W  = 3;

  typedef struct packed {
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] length;
    logic [15:0] chksum;
  } udp_pkt_hdr;

  typedef struct packed {
    logic [31:0] packet_num;
    logic [63:0] timestamp;
  } tracker_stats_struct;
endpackage

module udp_tx_app_arbiter
  import udp_tx_app_arbiter_pkg::*;
(
  input  logic                                  clk,
  input  logic                                  rst_n,

  input  logic [1:0]                            src_arb_hdr_val,
  input  logic [1:0][IP_ADDR_W-1:0]             src_arb_src_ip,
  input  logic [1:0][IP_ADDR_W-1:0]             src_arb_dst_ip,
  input  udp_pkt_hdr [1:0]                      src_arb_udp_hdr,
  input  tracker_stats_struct [1:0]             src_arb_timestamp,
  output logic [1:0]                            arb_src_hdr_rdy,

  input  logic [1:0]                            src_arb_data_val,
  input  logic [1:0][MAC_INTERFACE_W-1:0]       src_arb_data,
  input  logic [1:0]                            src_arb_data_last,
  input  logic [1:0][MAC_PADBYTES_W-1:0]        src_arb_data_padbytes,
  output logic [1:0]                            arb_src_data_rdy,

  output logic                                  arb_dst_hdr_val,
  input  logic                                  dst_arb_hdr_rdy,
  output logic [IP_ADDR_W-1:0]                  arb_dst_src_ip,
  output logic [IP_ADDR_W-1:0]                  arb_dst_dst_ip,
  output udp_pkt_hdr                            arb_dst_udp_hdr,
  output tracker_stats_struct                   arb_dst_timestamp,

  output logic                                  arb_dst_data_val,
  input  logic                                  dst_arb_data_rdy,
  output logic [MAC_INTERFACE_W-1:0]            arb_dst_data,
  output logic                                  arb_dst_data_last,
  output logic [MAC_PADBYTES_W-1:0]             arb_dst_data_padbytes,

  output logic                                  arb_owner,
  output logic                                  arb_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   prio_q,  prio_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
    end
  end

  // Grant is taken only in IDLE and held until the owner's last data beat.
  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    prio_d           = prio_q;
    arb_dst_hdr_val  = 1'b0;
    arb_src_hdr_rdy  = 2'b00;
    arb_dst_data_val = 1'b0;
    arb_src_data_rdy = 2'b00;

    case (state_q)
      IDLE: begin
        if (|src_arb_hdr_val) begin
          state_d = HDR;
          owner_d = (&src_arb_hdr_val) ? prio_q : src_arb_hdr_val[1];
        end
      end
      HDR: begin
        arb_dst_hdr_val           = src_arb_hdr_val[owner_q];
        arb_src_hdr_rdy[owner_q]  = dst_arb_hdr_rdy;
        if (src_arb_hdr_val[owner_q] && dst_arb_hdr_rdy) begin
          state_d = DATA;
        end
      end
      DATA: begin
        arb_dst_data_val          = src_arb_data_val[owner_q];
        arb_src_data_rdy[owner_q] = dst_arb_data_rdy;
        if (src_arb_data_val[owner_q] && dst_arb_data_rdy && src_arb_data_last[owner_q]) begin
          state_d = IDLE;
          prio_d  = ~owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Payload fields follow the owner in every state; only handshakes are gated.
  assign arb_dst_src_ip        = src_arb_src_ip[owner_q];
  assign arb_dst_dst_ip        = src_arb_dst_ip[owner_q];
  assign arb_dst_udp_hdr       = src_arb_udp_hdr[owner_q];
  assign arb_dst_timestamp     = src_arb_timestamp[owner_q];
  assign arb_dst_data          = src_arb_data[owner_q];
  assign arb_dst_data_last     = src_arb_data_last[owner_q];
  assign arb_dst_data_padbytes = src_arb_data_padbytes[owner_q];

  assign arb_owner = owner_q;
  assign arb_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_udp_tx_app_arbiter.sv
// Randomized scoreboard bench for udp_tx_app_arbiter: packet-level requesters,
// a transaction-level arbitration model and a per-cycle output monitor.
module tb_udp_tx_app_arbiter;
  import udp_tx_app_arbiter_pkg::*;

  typedef struct {
    logic [IP_ADDR_W-1:0]       src_ip;
    logic [IP_ADDR_W-1:0]       dst_ip;
    udp_pkt_hdr                 udp;
    tracker_stats_struct        ts;
    int                         nbeats;
    logic [MAC_PADBYTES_W-1:0]  pad;
    logic [MAC_INTERFACE_W-1:0] beats [8];
  } pkt_t;

  logic                             clk;
  logic                             rst_n;
  logic [1:0]                       src_arb_hdr_val;
  logic [1:0][IP_ADDR_W-1:0]        src_arb_src_ip;
  logic [1:0][IP_ADDR_W-1:0]        src_arb_dst_ip;
  udp_pkt_hdr [1:0]                 src_arb_udp_hdr;
  tracker_stats_struct [1:0]        src_arb_timestamp;
  logic [1:0]                       arb_src_hdr_rdy;
  logic [1:0]                       src_arb_data_val;
  logic [1:0][MAC_INTERFACE_W-1:0]  src_arb_data;
  logic [1:0]                       src_arb_data_last;
  logic [1:0][MAC_PADBYTES_W-1:0]   src_arb_data_padbytes;
  logic [1:0]                       arb_src_data_rdy;
  logic                             arb_dst_hdr_val;
  logic                             dst_arb_hdr_rdy;
  logic [IP_ADDR_W-1:0]             arb_dst_src_ip;
  logic [IP_ADDR_W-1:0]             arb_dst_dst_ip;
  udp_pkt_hdr                       arb_dst_udp_hdr;
  tracker_stats_struct              arb_dst_timestamp;
  logic                             arb_dst_data_val;
  logic                             dst_arb_data_rdy;
  logic [MAC_INTERFACE_W-1:0]       arb_dst_data;
  logic                             arb_dst_data_last;
  logic [MAC_PADBYTES_W-1:0]        arb_dst_data_padbytes;
  logic                             arb_owner;
  logic                             arb_busy;

  udp_tx_app_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .src_arb_hdr_val(src_arb_hdr_val), .src_arb_src_ip(src_arb_src_ip),
    .src_arb_dst_ip(src_arb_dst_ip), .src_arb_udp_hdr(src_arb_udp_hdr),
    .src_arb_timestamp(src_arb_timestamp), .arb_src_hdr_rdy(arb_src_hdr_rdy),
    .src_arb_data_val(src_arb_data_val), .src_arb_data(src_arb_data),
    .src_arb_data_last(src_arb_data_last), .src_arb_data_padbytes(src_arb_data_padbytes),
    .arb_src_data_rdy(arb_src_data_rdy),
    .arb_dst_hdr_val(arb_dst_hdr_val), .dst_arb_hdr_rdy(dst_arb_hdr_rdy),
    .arb_dst_src_ip(arb_dst_src_ip), .arb_dst_dst_ip(arb_dst_dst_ip),
    .arb_dst_udp_hdr(arb_dst_udp_hdr), .arb_dst_timestamp(arb_dst_timestamp),
    .arb_dst_data_val(arb_dst_data_val), .dst_arb_data_rdy(dst_arb_data_rdy),
    .arb_dst_data(arb_dst_data), .arb_dst_data_last(arb_dst_data_last),
    .arb_dst_data_padbytes(arb_dst_data_padbytes),
    .arb_owner(arb_owner), .arb_busy(arb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Stimulus configuration, written by the main sequence.
  int npk [2];
  int gap_max   = 0;
  int fixed_nb  = 0;
  int fixed_pad = -1;
  int sink_mode = 0;
  bit drop_en   = 1'b0;

  // Requester driver state.
  int   ph [2];
  int   bt [2];
  int   gap [2];
  pkt_t cur [2];
  logic hs_h [2];
  logic hs_d [2];
  pkt_t src_q0 [$];
  pkt_t src_q1 [$];

  // Reference model state.
  int   model_ph = 0;
  logic m_owner  = 1'b0;
  logic m_prio   = 1'b0;
  pkt_t exp_q [$];
  pkt_t mon_pkt;
  int   cur_beat = 0;
  int   hdr_wait = 0;
  int   last_hdr_wait = 0;
  int   data_hs_total = 0;
  int   grants [$];

  // Requesters and sink: sample handshakes at negedge, update after posedge.
  initial begin
    pkt_t p;
    for (int i = 0; i < 2; i++) begin npk[i] = 0; ph[i] = 0; bt[i] = 0; gap[i] = 0; end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        hs_h[i] = src_arb_hdr_val[i] & arb_src_hdr_rdy[i];
        hs_d[i] = src_arb_data_val[i] & arb_src_data_rdy[i];
      end
      @(posedge clk);
      #1;
      case (sink_mode)
        0: begin dst_arb_hdr_rdy = 1'b1; dst_arb_data_rdy = 1'b1; end
        1: begin dst_arb_hdr_rdy = 1'($urandom_range(1, 0)); dst_arb_data_rdy = 1'($urandom_range(1, 0)); end
        2: begin dst_arb_hdr_rdy = 1'b1; dst_arb_data_rdy = ~dst_arb_data_rdy; end
        default: begin dst_arb_hdr_rdy = (hdr_wait >= 5); dst_arb_data_rdy = 1'b1; end
      endcase
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          ph[i] = 0; gap[i] = 0;
          src_arb_hdr_val[i] = 1'b0; src_arb_data_val[i] = 1'b0; src_arb_data_last[i] = 1'b0;
        end else begin
          if (ph[i] == 1 && hs_h[i]) begin
            ph[i] = 2; bt[i] = 0; src_arb_hdr_val[i] = 1'b0;
          end else if (ph[i] == 2 && hs_d[i]) begin
            bt[i]++;
            if (bt[i] == cur[i].nbeats) begin ph[i] = 0; gap[i] = int'($urandom_range(gap_max, 0)); end
          end
          if (ph[i] == 1) src_arb_hdr_val[i] = drop_en ? ($urandom_range(3, 0) != 0) : 1'b1;
          if (ph[i] == 0) begin
            src_arb_data_val[i] = 1'b0; src_arb_data_last[i] = 1'b0;
            if (npk[i] > 0) begin
              if (gap[i] > 0) gap[i]--;
              else begin
                p.src_ip = $urandom; p.dst_ip = $urandom;
                p.udp    = udp_pkt_hdr'({$urandom, $urandom});
                p.ts     = tracker_stats_struct'({$urandom, $urandom, $urandom});
                p.nbeats = (fixed_nb > 0) ? fixed_nb : int'($urandom_range(8, 1));
                p.pad    = (fixed_pad >= 0) ? MAC_PADBYTES_W'(fixed_pad) : MAC_PADBYTES_W'($urandom_range(7, 0));
                for (int b = 0; b < 8; b++) p.beats[b] = {$urandom, $urandom};
                cur[i] = p;
                if (i == 0) src_q0.push_back(p); else src_q1.push_back(p);
                src_arb_src_ip[i] = p.src_ip; src_arb_dst_ip[i] = p.dst_ip;
                src_arb_udp_hdr[i] = p.udp; src_arb_timestamp[i] = p.ts;
                src_arb_hdr_val[i] = 1'b1;
                ph[i] = 1; npk[i]--;
              end
            end
          end
          if (ph[i] == 2) begin
            src_arb_data_val[i]      = ($urandom_range(3, 0) != 0);
            src_arb_data[i]          = cur[i].beats[bt[i]];
            src_arb_data_last[i]     = (bt[i] == cur[i].nbeats - 1);
            src_arb_data_padbytes[i] = src_arb_data_last[i] ? cur[i].pad : '0;
          end
        end
      end
    end
  end

  // Monitor + transaction-level arbitration model (IDLE -> granted header -> payload).
  initial begin
    logic       w;
    logic [1:0] exp_rdy;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_ph = 0; m_owner = 1'b0; m_prio = 1'b0; cur_beat = 0; hdr_wait = 0;
        src_q0.delete(); src_q1.delete(); exp_q.delete();
      end else begin
        case (model_ph)
          0: begin
            chk("idle_outputs", 128'({arb_dst_hdr_val, arb_dst_data_val, arb_src_hdr_rdy, arb_src_data_rdy, arb_busy}), 128'(0));
            if (|src_arb_hdr_val) begin
              w = (&src_arb_hdr_val) ? m_prio : src_arb_hdr_val[1];
              m_owner = w; model_ph = 1; hdr_wait = 0;
              grants.push_back(int'(w));
              if (w == 1'b0 && src_q0.size() > 0) exp_q.push_back(src_q0.pop_front());
              else if (w == 1'b1 && src_q1.size() > 0) exp_q.push_back(src_q1.pop_front());
              else chk("grant_has_packet", 128'(0), 128'(1));
            end
          end
          1: begin
            exp_rdy = 2'b00; exp_rdy[m_owner] = dst_arb_hdr_rdy;
            chk("hdr_busy", 128'(arb_busy), 128'(1));
            chk("hdr_owner", 128'(arb_owner), 128'(m_owner));
            chk("hdr_val", 128'(arb_dst_hdr_val), 128'(src_arb_hdr_val[m_owner]));
            chk("hdr_rdy", 128'(arb_src_hdr_rdy), 128'(exp_rdy));
            chk("hdr_data_blocked", 128'({arb_dst_data_val, arb_src_data_rdy}), 128'(0));
            if (arb_dst_hdr_val && !dst_arb_hdr_rdy) hdr_wait++;
            if (src_arb_hdr_val[m_owner] && dst_arb_hdr_rdy) begin
              last_hdr_wait = hdr_wait;
              if (exp_q.size() > 0) begin
                mon_pkt = exp_q.pop_front();
                chk("hdr_src_ip", 128'(arb_dst_src_ip), 128'(mon_pkt.src_ip));
                chk("hdr_dst_ip", 128'(arb_dst_dst_ip), 128'(mon_pkt.dst_ip));
                chk("hdr_udp", 128'(arb_dst_udp_hdr), 128'(mon_pkt.udp));
                chk("hdr_ts", 128'(arb_dst_timestamp), 128'(mon_pkt.ts));
              end else chk("hdr_expected", 128'(0), 128'(1));
              model_ph = 2; cur_beat = 0;
            end
          end
          default: begin
            exp_rdy = 2'b00; exp_rdy[m_owner] = dst_arb_data_rdy;
            chk("data_owner", 128'(arb_owner), 128'(m_owner));
            chk("data_val", 128'(arb_dst_data_val), 128'(src_arb_data_val[m_owner]));
            chk("data_rdy", 128'(arb_src_data_rdy), 128'(exp_rdy));
            chk("data_hdr_blocked", 128'({arb_dst_hdr_val, arb_src_hdr_rdy}), 128'(0));
            if (src_arb_data_val[m_owner] && dst_arb_data_rdy) begin
              data_hs_total++;
              chk("beat_data", 128'(arb_dst_data), 128'(mon_pkt.beats[cur_beat]));
              chk("beat_last", 128'(arb_dst_data_last), 128'(cur_beat == mon_pkt.nbeats - 1));
              if (cur_beat == mon_pkt.nbeats - 1) begin
                chk("beat_pad", 128'(arb_dst_data_padbytes), 128'(mon_pkt.pad));
                model_ph = 0; m_prio = ~m_owner;
              end
              cur_beat++;
            end
          end
        endcase
      end
    end
  end

  task automatic wait_done(input string nm, input int budget);
    bit done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(posedge clk);
      #2;
      done = (npk[0] == 0 && npk[1] == 0 && ph[0] == 0 && ph[1] == 0 && model_ph == 0
              && src_q0.size() == 0 && src_q1.size() == 0 && exp_q.size() == 0);
    end
    chk({"done_", nm}, 128'(done), 128'(1));
  endtask

  task automatic chk_grant(input string nm, input int idx, input int exp);
    if (idx < grants.size()) chk(nm, 128'(grants[idx]), 128'(exp));
    else chk({nm, "_missing"}, 128'(0), 128'(1));
  endtask

  initial begin
    int g0;
    int d0;
    bit hit;
    rst_n = 1'b0;
    dst_arb_hdr_rdy = 1'b1; dst_arb_data_rdy = 1'b1;
    src_arb_hdr_val = '0; src_arb_data_val = '0; src_arb_data_last = '0;
    src_arb_src_ip = '0; src_arb_dst_ip = '0; src_arb_udp_hdr = '0; src_arb_timestamp = '0;
    src_arb_data = '0; src_arb_data_padbytes = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valrdy", 128'({arb_dst_hdr_val, arb_dst_data_val, arb_src_hdr_rdy, arb_src_data_rdy}), 128'(0));
    chk("reset_owner_busy", 128'({arb_owner, arb_busy}), 128'(0));
    @(negedge clk); #2; rst_n = 1'b1;

    // Single requester 1: 3 beats, pad 5.
    fixed_nb = 3; fixed_pad = 5; sink_mode = 0;
    g0 = grants.size(); d0 = data_hs_total;
    npk[1] = 1;
    wait_done("single", 200);
    chk_grant("single_grant", g0, 1);
    chk("single_owner", 128'(arb_owner), 128'(1));
    chk("single_beats", 128'(data_hs_total - d0), 128'(3));

    // Contention with continuous requests: strictly alternating from req0.
    fixed_nb = 2; fixed_pad = -1;
    g0 = grants.size();
    npk[0] = 4; npk[1] = 4;
    wait_done("contention", 400);
    for (int k = 0; k < 8; k++) chk_grant("alt_grant", g0 + k, k % 2);

    // Toggling data backpressure on a 4-beat packet.
    sink_mode = 2; fixed_nb = 4;
    d0 = data_hs_total;
    npk[0] = 1;
    wait_done("backpressure", 200);
    chk("bp_beats", 128'(data_hs_total - d0), 128'(4));

    // Header stall of 5 cycles.
    sink_mode = 3; fixed_nb = 2;
    npk[0] = 1;
    wait_done("hdr_stall", 200);
    chk("hdr_stall_cycles", 128'(last_hdr_wait), 128'(5));

    // Randomized mixed traffic with header drops and random sink.
    sink_mode = 1; fixed_nb = 0; gap_max = 3; drop_en = 1'b1;
    npk[0] = 20; npk[1] = 20;
    wait_done("random", 4000);
    drop_en = 1'b0; gap_max = 0;

    // Reset after beat 2 of a 4-beat packet.
    sink_mode = 0; fixed_nb = 4;
    npk[1] = 1;
    hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(posedge clk);
      hit = (model_ph == 2 && cur_beat == 2);
    end
    chk("reset_reached_beat2", 128'(hit), 128'(1));
    #2; rst_n = 1'b0;
    #1;
    chk("mid_reset_valrdy", 128'({arb_dst_hdr_val, arb_dst_data_val, arb_src_hdr_rdy, arb_src_data_rdy}), 128'(0));
    chk("mid_reset_owner_busy", 128'({arb_owner, arb_busy}), 128'(0));
    repeat (3) @(posedge clk);
    @(negedge clk); #2; rst_n = 1'b1;
    #1;
    g0 = grants.size();
    fixed_nb = 2;
    npk[1] = 1;
    wait_done("post_reset", 200);
    chk_grant("post_reset_grant", g0, 1);

    // Contention after that packet: prio returned to req0.
    g0 = grants.size();
    npk[0] = 1; npk[1] = 1;
    wait_done("post_reset_contention", 200);
    chk_grant("post_reset_alt0", g0, 0);
    chk_grant("post_reset_alt1", g0 + 1, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/udp_tx_app_arbiter.md
UDP_TX_APP_ARBITER -- requirements
Module: udp_tx_app_arbiter

Interface
REQ-001 Parameters: none; widths SHALL come from IP_ADDR_W, MAC_INTERFACE_W and MAC_PADBYTES_W (packet_defs.vh), and from udp_pkt_hdr / tracker_stats_struct.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 src_arb_hdr_val  in  [1:0]  per-requester header valid.
REQ-005 src_arb_src_ip / src_arb_dst_ip  in  [1:0][IP_ADDR_W]  per-requester IP addresses.
REQ-006 src_arb_udp_hdr  in  udp_pkt_hdr[1:0]  per-requester UDP header.
REQ-007 src_arb_timestamp  in  tracker_stats_struct[1:0]  per-requester timestamp.
REQ-008 arb_src_hdr_rdy  out  [1:0]  per-requester header ready.
REQ-009 src_arb_data_val / src_arb_data_last  in  [1:0]  per-requester data valid / last beat.
REQ-010 src_arb_data  in  [1:0][MAC_INTERFACE_W]  per-requester payload beat.
REQ-011 src_arb_data_padbytes  in  [1:0][MAC_PADBYTES_W]  per-requester pad bytes on the last beat.
REQ-012 arb_src_data_rdy  out  [1:0]  per-requester data ready.
REQ-013 arb_dst_hdr_val / dst_arb_hdr_rdy  out / in  1  merged header handshake.
REQ-014 arb_dst_src_ip, arb_dst_dst_ip, arb_dst_udp_hdr, arb_dst_timestamp  out  as inputs  merged header fields.
REQ-015 arb_dst_data_val / dst_arb_data_rdy  out / in  1  merged data handshake.
REQ-016 arb_dst_data, arb_dst_data_last, arb_dst_data_padbytes  out  as inputs  merged data fields.
REQ-017 arb_owner  out  1  index of the current or last granted requester.
REQ-018 arb_busy  out  1  high in HDR or DATA state.

Function
REQ-019 The FSM SHALL have three states: IDLE, HDR and DATA.
REQ-020 IDLE: if any src_arb_hdr_val bit is high, the grant SHALL be registered into owner and the FSM SHALL go to HDR on the next edge; a single requester SHALL win directly; with both high, prio SHALL win.
REQ-021 In IDLE, every val and rdy output SHALL be 0, and no input SHALL be consumed (1-cycle arbitration bubble).
REQ-022 HDR: arb_dst_hdr_val = src_arb_hdr_val[owner], and arb_src_hdr_rdy[owner] = dst_arb_hdr_rdy; the other requester's rdy SHALL be 0; on handshake the FSM SHALL go to DATA.
REQ-023 HDR: data handshakes SHALL be blocked (arb_dst_data_val=0, arb_src_data_rdy=0).
REQ-024 DATA: arb_dst_data_val = src_arb_data_val[owner], and arb_src_data_rdy[owner] = dst_arb_data_rdy; header rdy SHALL be 0.
REQ-025 DATA: on val&rdy&last, the FSM SHALL return to IDLE and set prio <= ~owner; the grant SHALL never change mid-packet.
REQ-026 Field outputs SHALL be combinationally muxed from owner in all states; only val/rdy are gated by state.
REQ-027 Header-to-downstream and data-to-downstream paths SHALL add no register stage; arbitration SHALL be the only added latency.
REQ-028 A requester dropping hdr_val while in HDR SHALL NOT cause an exit from HDR; the FSM SHALL wait.
REQ-029 Back-to-back traffic from one requester only SHALL cost exactly one IDLE cycle per packet.
REQ-030 Both requesters continuously requesting SHALL produce strictly alternating grants.

Reset
REQ-031 Asserting rst_n low SHALL immediately force state=IDLE, owner=0, prio=0, and all val/rdy outputs to 0, arb_busy=0.
REQ-032 Reset mid-packet SHALL abandon the packet with no recovery; requesters SHALL be reset together with this block.

Verification
REQ-033 Single requester: req1 header, then 3 data beats (last with padbytes=5) -> owner=1, hdr out on cycle 2, 3 beats out unchanged, padbytes=5, return to IDLE.
REQ-034 Contention after reset: both hdr_val high in the same cycle -> req0 served first, then req1; with continuous requests, grants alternate 0,1,0,1.
REQ-035 Backpressure: dst_arb_data_rdy toggling 1/0 during a 4-beat packet -> exactly 4 beats transferred, in order, none duplicated; the non-owner's rdy stays 0 throughout.
REQ-036 Header stall: dst_arb_hdr_rdy=0 for 5 cycles -> FSM stays in HDR, the owner's data rdy stays 0, data passes only after the header handshake.
REQ-037 Reset in DATA: rst_n low after beat 2 of 4 -> all val/rdy outputs 0 that cycle; after release, a fresh req1 packet is granted normally with prio=0.
